accumulator_drain_unit: RTL and testbench

Read-side counterpart of the accumulator control path. Once a matrix-multiply instruction has finished writing its results into the accumulator banks, this block reads every result row back out. It requantizes each row's MUL_SIZE signed 32-bit lanes to signed 8-bit values and streams the rows over a valid/ready interface to the unified-buffer writer. Backpressure is absorbed by a 2-entry output FIFO with credit-based read issue.

---
 rtl/accumulator_drain_unit.sv | 167 ++++++++++++++++
 tb/tb_accumulator_drain_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_drain_unit.sv
// accumulator_drain_unit: streams requantized accumulator rows to the UB writer.
// Optional DRAIN_RELU_EN clamps negative lanes to zero before saturation.
module accumulator_drain_unit #(
    parameter int MUL_SIZE = 32,
    parameter int ACC_W    = 32,
    parameter int ADDR_W   = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [7:0]                V_dim_i,
    input  logic [7:0]                U_dim_i,
    input  logic [4:0]                shift_i,
    input  logic [ADDR_W-1:0]         out_base_i,
    output logic                      busy_o,
    output logic                      acc_rd_en_o,
    output logic [ADDR_W-1:0]         acc_rd_addr_o,
    input  logic [MUL_SIZE*ACC_W-1:0] acc_rd_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [MUL_SIZE*8-1:0]     out_data_o,
    output logic [ADDR_W-1:0]         out_addr_o,
    output logic                      out_last_o,
    output logic                      done_o
);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] SAT_LO = -(ACC_W+1)'(128);

    state_t state_q, state_d;

    logic [15:0]           prod_d, rows_d, rows_q;
    logic [15:0]           rd_idx_q, beat_q;
    logic [4:0]            shift_q;
    logic [ADDR_W-1:0]     base_q;
    logic                  zero_done_q, inflight_q;
    logic [1:0]            count_q;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [MUL_SIZE*8-1:0] mem_q [2];
    logic [MUL_SIZE*8-1:0] req_row;
    logic                  start_ok, pop, credit_ok, rd_en, flush_done;
    logic [2:0]            occ;

    logic signed [ACC_W:0] ext, rnd, t;
    logic [7:0]            q;

    assign prod_d    = {8'd0, V_dim_i} * {8'd0, U_dim_i};
    assign rows_d    = {5'd0, prod_d[15:5]};
    assign start_ok  = start_i && (state_q == IDLE) && !zero_done_q;
    assign out_valid_o = (count_q != 2'd0);
    assign pop       = out_valid_o && out_ready_i;
    assign occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign credit_ok = (occ < 3'd2);

    assign acc_rd_en_o   = rd_en;
    assign acc_rd_addr_o = rd_idx_q[ADDR_W-1:0];
    assign out_data_o    = mem_q[rd_ptr_q];
    assign out_addr_o    = base_q + beat_q[ADDR_W-1:0];
    assign out_last_o    = out_valid_o && (beat_q == rows_q - 16'd1);
    assign done_o        = flush_done || zero_done_q;
    assign busy_o        = (state_q != IDLE) && !flush_done;

    // Per-lane round-half-up shift and saturation to int8.
    always_comb begin
        req_row = '0;
        ext = '0;
        rnd = '0;
        t = '0;
        q = '0;
        for (int i = 0; i < MUL_SIZE; i++) begin
            ext = {acc_rd_data_i[i*ACC_W+ACC_W-1], acc_rd_data_i[i*ACC_W +: ACC_W]};
            rnd = '0;
            if (shift_q != 5'd0)
                rnd[shift_q - 5'd1] = 1'b1;
            t = (ext + rnd) >>> shift_q;
`ifdef DRAIN_RELU_EN
            if (t[ACC_W])
                t = '0;
`endif
            if (t > SAT_HI)
                q = 8'h7f;
            else if (t < SAT_LO)
                q = 8'h80;
            else
                q = t[7:0];
            req_row[i*8 +: 8] = q;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, credit-gated read issue and flush completion.
    always_comb begin
        state_d = state_q;
        rd_en = 1'b0;
        flush_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok && rows_d != 16'd0)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (rd_idx_q == rows_q - 16'd1)
                        state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (count_q == 2'd0 && !inflight_q) begin
                    flush_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain parameters, row/beat counters and the 2-entry output FIFO.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rows_q      <= '0;
            shift_q     <= '0;
            base_q      <= '0;
            rd_idx_q    <= '0;
            beat_q      <= '0;
            zero_done_q <= 1'b0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            for (int i = 0; i < 2; i++)
                mem_q[i] <= '0;
        end else begin
            zero_done_q <= start_ok && (rows_d == 16'd0);
            if (start_ok) begin
                rows_q   <= rows_d;
                shift_q  <= shift_i;
                base_q   <= out_base_i;
                rd_idx_q <= '0;
                beat_q   <= '0;
            end else begin
                if (rd_en)
                    rd_idx_q <= rd_idx_q + 16'd1;
                if (pop)
                    beat_q <= beat_q + 16'd1;
            end
            inflight_q <= rd_en;
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= req_row;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_accumulator_drain_unit.sv
// tb_accumulator_drain_unit: directed checks of the accumulator drain stream.
// Expected lanes follow DRAIN_RELU_EN when it is defined.
module tb_accumulator_drain_unit;

    localparam int MS  = 32;
    localparam int AW  = 32;
    localparam int ADW = 10;
`ifdef DRAIN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [7:0]        V_dim_i;
    logic [7:0]        U_dim_i;
    logic [4:0]        shift_i;
    logic [ADW-1:0]    out_base_i;
    logic              busy_o;
    logic              acc_rd_en_o;
    logic [ADW-1:0]    acc_rd_addr_o;
    logic [MS*AW-1:0]  acc_rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [MS*8-1:0]   out_data_o;
    logic [ADW-1:0]    out_addr_o;
    logic              out_last_o;
    logic              done_o;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    logic mode_row = 1'b0;
    logic [MS*AW-1:0] pat = '0;

    accumulator_drain_unit #(.MUL_SIZE(MS), .ACC_W(AW), .ADDR_W(ADW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .V_dim_i(V_dim_i), .U_dim_i(U_dim_i), .shift_i(shift_i),
        .out_base_i(out_base_i), .busy_o(busy_o),
        .acc_rd_en_o(acc_rd_en_o), .acc_rd_addr_o(acc_rd_addr_o),
        .acc_rd_data_i(acc_rd_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_addr_o(out_addr_o), .out_last_o(out_last_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [MS*AW-1:0] row_data(input logic [ADW-1:0] a);
        logic [MS*AW-1:0] d;
        d = '0;
        d[31:0] = 32'(a);
        d[63:32] = -32'(a);
        return d;
    endfunction

    // Accumulator model: one-cycle read latency.
    always @(posedge clk_i) begin
        if (acc_rd_en_o) begin
            rd_cnt <= rd_cnt + 1;
            acc_rd_data_i <= mode_row ? row_data(acc_rd_addr_o) : pat;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic kick(input logic [7:0] v, input logic [7:0] u,
                        input logic [4:0] s, input logic [ADW-1:0] b);
        V_dim_i = v;
        U_dim_i = u;
        shift_i = s;
        out_base_i = b;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (3) step();
        total++;
        if ({busy_o, acc_rd_en_o, out_valid_o, out_last_o, done_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=00000",
                     {busy_o, acc_rd_en_o, out_valid_o, out_last_o, done_o});
        end
        total++;
        if (acc_rd_addr_o !== '0 || out_addr_o !== '0 || out_data_o !== '0) begin
            bad++;
            $display("FAIL reset_data rd_addr=%0d out_addr=%0d data=%h",
                     acc_rd_addr_o, out_addr_o, out_data_o);
        end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_single();
        int r0;
        logic [31:0] exp;
        exp = RELU ? 32'h007f0005 : 32'h807ffd05;
        pat = '0;
        pat[31:0] = 32'sd5;
        pat[63:32] = -32'sd3;
        pat[95:64] = 32'sd200;
        pat[127:96] = -32'sd500;
        mode_row = 1'b0;
        out_ready_i = 1'b1;
        r0 = rd_cnt;
        kick(8'd4, 8'd8, 5'd0, 10'd5);
        total++;
        if ({busy_o, acc_rd_en_o} !== 2'b11 || acc_rd_addr_o !== 10'd0) begin
            bad++;
            $display("FAIL single_c1 busy=%b rd_en=%b addr=%0d want 1 1 0",
                     busy_o, acc_rd_en_o, acc_rd_addr_o);
        end
        step();
        total++;
        if (out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_c2_valid got=%b want=0", out_valid_o);
        end
        step();
        total++;
        if (out_valid_o !== 1'b1 || out_data_o[31:0] !== exp || out_data_o[MS*8-1:32] !== '0) begin
            bad++;
            $display("FAIL single_c3_data valid=%b data=%h want=%h",
                     out_valid_o, out_data_o[31:0], exp);
        end
        total++;
        if (out_last_o !== 1'b1 || out_addr_o !== 10'd5 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL single_c3_meta last=%b addr=%0d done=%b want 1 5 0",
                     out_last_o, out_addr_o, done_o);
        end
        step();
        total++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL single_c4_done done=%b busy=%b want 1 0", done_o, busy_o);
        end
        step();
        total++;
        if (done_o !== 1'b0 || rd_cnt - r0 !== 1) begin
            bad++;
            $display("FAIL single_c5 done=%b reads=%0d want 0 1", done_o, rd_cnt - r0);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] exp;
        exp = RELU ? 32'h00000001 : 32'hff000001;
        pat = '0;
        pat[31:0] = 32'sd8;
        pat[63:32] = 32'sd7;
        pat[95:64] = -32'sd8;
        pat[127:96] = -32'sd9;
        mode_row = 1'b0;
        out_ready_i = 1'b1;
        kick(8'd4, 8'd8, 5'd4, 10'd0);
        step();
        step();
        total++;
        if (out_valid_o !== 1'b1 || out_data_o[31:0] !== exp) begin
            bad++;
            $display("FAIL rounding valid=%b data=%h want=%h",
                     out_valid_o, out_data_o[31:0], exp);
        end
        step();
        total++;
        if (done_o !== 1'b1) begin
            bad++;
            $display("FAIL rounding_done got=%b want=1", done_o);
        end
        step();
    endtask

    task automatic test_stream();
        logic [15:0] rp;
        int k;
        logic stalled, seen_done;
        logic [MS*8-1:0] h_data;
        logic [ADW-1:0] h_addr;
        logic h_last;
        rp = 16'b1010_1101_0100_1011;
        k = 0;
        stalled = 1'b0;
        seen_done = 1'b0;
        h_data = '0;
        h_addr = '0;
        h_last = 1'b0;
        mode_row = 1'b1;
        out_ready_i = 1'b0;
        kick(8'd32, 8'd64, 5'd0, 10'd1000);
        for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
            out_ready_i = rp[cyc % 16];
            if (stalled) begin
                total++;
                if (out_valid_o !== 1'b1 || out_data_o !== h_data ||
                    out_addr_o !== h_addr || out_last_o !== h_last) begin
                    bad++;
                    $display("FAIL stream_hold valid=%b addr=%0d want_addr=%0d",
                             out_valid_o, out_addr_o, h_addr);
                end
            end
            stalled = 1'b0;
            if (out_valid_o) begin
                if (out_ready_i) begin
                    total++;
                    if (out_addr_o !== ADW'(1000 + k) || out_data_o[7:0] !== 8'(k) ||
                        out_data_o[15:8] !== (RELU ? 8'h00 : 8'(-k)) ||
                        out_last_o !== (k == 63)) begin
                        bad++;
                        $display("FAIL stream_beat k=%0d addr=%0d l0=%0d l1=%h last=%b",
                                 k, out_addr_o, out_data_o[7:0], out_data_o[15:8], out_last_o);
                    end
                    k++;
                end else begin
                    stalled = 1'b1;
                    h_data = out_data_o;
                    h_addr = out_addr_o;
                    h_last = out_last_o;
                end
            end
            if (done_o)
                seen_done = 1'b1;
            step();
        end
        total++;
        if (k !== 64 || seen_done !== 1'b1) begin
            bad++;
            $display("FAIL stream_count beats=%0d done=%b want 64 1", k, seen_done);
        end
        out_ready_i = 1'b1;
        step();
    endtask

    task automatic test_hold();
        int r0;
        mode_row = 1'b1;
        out_ready_i = 1'b0;
        r0 = rd_cnt;
        kick(8'd32, 8'd64, 5'd0, 10'd0);
        repeat (20) step();
        total++;
        if (rd_cnt - r0 !== 2 || out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_stall reads=%0d valid=%b busy=%b want 2 1 1",
                     rd_cnt - r0, out_valid_o, busy_o);
        end
        out_ready_i = 1'b1;
        for (int k = 0; k < 64; k++) begin
            total++;
            if (out_valid_o !== 1'b1 || out_addr_o !== ADW'(k) || out_data_o[7:0] !== 8'(k)) begin
                bad++;
                $display("FAIL hold_resume k=%0d valid=%b addr=%0d l0=%0d",
                         k, out_valid_o, out_addr_o, out_data_o[7:0]);
            end
            step();
        end
        total++;
        if (done_o !== 1'b1 || rd_cnt - r0 !== 64) begin
            bad++;
            $display("FAIL hold_done done=%b reads=%0d want 1 64", done_o, rd_cnt - r0);
        end
        step();
    endtask

    task automatic test_zero();
        int r0;
        out_ready_i = 1'b1;
        r0 = rd_cnt;
        kick(8'd0, 8'd8, 5'd0, 10'd0);
        total++;
        if ({done_o, busy_o, acc_rd_en_o, out_valid_o} !== 4'b1000) begin
            bad++;
            $display("FAIL zero_c1 done,busy,rd_en,valid=%b want=1000",
                     {done_o, busy_o, acc_rd_en_o, out_valid_o});
        end
        step();
        total++;
        if (done_o !== 1'b0 || out_valid_o !== 1'b0 || rd_cnt !== r0) begin
            bad++;
            $display("FAIL zero_c2 done=%b valid=%b reads=%0d want 0 0 0",
                     done_o, out_valid_o, rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        int k, n;
        logic seen_done;
        k = 0;
        mode_row = 1'b1;
        out_ready_i = 1'b1;
        kick(8'd32, 8'd64, 5'd0, 10'd100);
        for (int cyc = 0; cyc < 200 && k < 10; cyc++) begin
            if (out_valid_o && out_ready_i)
                k++;
            step();
        end
        rst_i = 1'b0;
        #1;
        total++;
        if ({busy_o, acc_rd_en_o, out_valid_o, out_last_o, done_o} !== 5'b0 ||
            acc_rd_addr_o !== '0 || out_addr_o !== '0 || out_data_o !== '0) begin
            bad++;
            $display("FAIL midreset_outs flags=%b rd_addr=%0d out_addr=%0d",
                     {busy_o, acc_rd_en_o, out_valid_o, out_last_o, done_o},
                     acc_rd_addr_o, out_addr_o);
        end
        #2;
        rst_i = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done_o)
                seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_nodone got=%b want=0", seen_done);
        end
        n = 0;
        seen_done = 1'b0;
        kick(8'd2, 8'd32, 5'd0, 10'd7);
        for (int cyc = 0; cyc < 50 && !seen_done; cyc++) begin
            if (out_valid_o && out_ready_i) begin
                total++;
                if (out_addr_o !== ADW'(7 + n) || out_last_o !== (n == 1) ||
                    out_data_o[7:0] !== 8'(n)) begin
                    bad++;
                    $display("FAIL midreset_beat n=%0d addr=%0d last=%b l0=%0d",
                             n, out_addr_o, out_last_o, out_data_o[7:0]);
                end
                n++;
            end
            if (done_o)
                seen_done = 1'b1;
            step();
        end
        total++;
        if (n !== 2 || seen_done !== 1'b1) begin
            bad++;
            $display("FAIL midreset_count beats=%0d done=%b want 2 1", n, seen_done);
        end
    endtask

    initial begin
        start_i = 1'b0;
        V_dim_i = '0;
        U_dim_i = '0;
        shift_i = '0;
        out_base_i = '0;
        out_ready_i = 1'b0;
        test_reset();
        test_single();
        test_rounding();
        test_stream();
        test_hold();
        test_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
